// File: rtl/fp_addsub_pkg.sv
// Shared constants, response entry layout and flag helper for the FP add/sub issue wrapper.
// Optional status flags are enabled with FP_ADDSUB_STATUS_EN.
package fp_addsub_pkg;

   localparam int FP_ADDSUB_LATENCY = 13;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FLAG_NAN  = 2;
   localparam int FLAG_INF  = 1;
   localparam int FLAG_ZERO = 0;

   typedef struct packed {
      logic [31:0] s;
`ifdef FP_ADDSUB_STATUS_EN
      logic [2:0]  flags;
`endif
   } resp_entry_t;

`ifdef FP_ADDSUB_STATUS_EN
   function automatic logic [2:0] fp_flags(input logic [31:0] s);
      logic [2:0] f;
      f = '0;
      f[FLAG_NAN]  = (s[30:23] == 8'hFF) && (s[22:0] != 23'd0);
      f[FLAG_INF]  = (s[30:23] == 8'hFF) && (s[22:0] == 23'd0);
      f[FLAG_ZERO] = (s[30:23] == 8'h00) && (s[22:0] == 23'd0);
      return f;
   endfunction
`endif

endpackage

// File: rtl/fp_resp_fifo.sv
// In-order response FIFO: synchronous push/pop, head word visible on pop_data while not empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fp_resp_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 36
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue/writeback wrapper for the fixed-latency FP add/sub pipeline, with credit-based backpressure.
// Define FP_ADDSUB_STATUS_EN to add {nan, inf, zero} result flags (io_resp_flags).
module fp_addsub_issue
   import fp_addsub_pkg::*;
#(
   parameter int LATENCY    = FP_ADDSUB_LATENCY,
   parameter int FIFO_DEPTH = 16,
   parameter int TAG_W      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_req_valid,
   output logic             io_req_ready,
   input  logic             io_req_op,
   input  logic [31:0]      io_req_a,
   input  logic [31:0]      io_req_b,
   input  logic [TAG_W-1:0] io_req_tag,
   output logic             io_fpu_en,
   output logic [31:0]      io_fpu_a,
   output logic [31:0]      io_fpu_b,
   input  logic [31:0]      io_fpu_s,
   output logic             io_resp_valid,
   input  logic             io_resp_ready,
   output logic [31:0]      io_resp_s,
   output logic [TAG_W-1:0] io_resp_tag,
`ifdef FP_ADDSUB_STATUS_EN
   output logic [2:0]       io_resp_flags,
`endif
   output logic             io_busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = $bits(resp_entry_t) + TAG_W;

   logic [CW-1:0]    cnt;
   logic [LATENCY:0] v;
   logic [TAG_W-1:0] t [LATENCY+1];
   logic             fpu_en_q;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic             accept;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   resp_entry_t      push_entry;
   resp_entry_t      pop_entry;
   logic [EW-1:0]    pop_data;

   // Handshakes: a transfer happens on a rising edge where valid && ready; ready depends only
   // on registered credit state, and the sender holds its payload until the transfer.
   assign io_req_ready  = (cnt < CW'(FIFO_DEPTH));
   assign accept        = io_req_valid && io_req_ready;
   assign io_resp_valid = !fifo_empty;
   assign pop           = io_resp_valid && io_resp_ready;
   assign push          = v[LATENCY];
   assign io_busy       = (cnt != '0);
   assign io_fpu_en     = fpu_en_q;
   assign io_fpu_a      = op_a;
   assign io_fpu_b      = op_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fpu_en_q <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         v        <= '0;
         cnt      <= '0;
         for (int i = 0; i <= LATENCY; i++) t[i] <= '0;
      end else begin
         fpu_en_q <= 1'b1;
         v[0]     <= accept;
         if (accept) begin
            op_a <= io_req_a;
            op_b <= {io_req_b[31] ^ (io_req_op == OP_SUB), io_req_b[30:0]};
            t[0] <= io_req_tag;
         end
         // Valid/tag ride alongside the free-running datapath; bubbles are v=0 slots.
         for (int i = 1; i <= LATENCY; i++) begin
            v[i] <= v[i-1];
            t[i] <= t[i-1];
         end
         if (accept && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !accept) cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      push_entry   = '0;
      push_entry.s = io_fpu_s;
`ifdef FP_ADDSUB_STATUS_EN
      push_entry.flags = fp_flags(io_fpu_s);
`endif
   end

   fp_resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_resp_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({push_entry, t[LATENCY]}),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign pop_entry   = pop_data[EW-1:TAG_W];
   assign io_resp_tag = pop_data[TAG_W-1:0];
   assign io_resp_s   = pop_entry.s;
`ifdef FP_ADDSUB_STATUS_EN
   assign io_resp_flags = pop_entry.flags;
`endif

   // Credits bound in-flight plus stored results to FIFO_DEPTH, so this must never fire.
   no_push_when_full: assert property (@(posedge clock) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Bench for fp_addsub_issue: a 13-stage datapath stand-in, vector table, directed corner cases
// and randomized traffic checked by an in-order scoreboard.
module tb_fp_addsub_issue;
   import fp_addsub_pkg::*;

   localparam int TAG_W = 4;
   localparam int LAT   = 13;

   logic             clock;
   logic             reset;
   logic             io_req_valid;
   logic             io_req_ready;
   logic             io_req_op;
   logic [31:0]      io_req_a;
   logic [31:0]      io_req_b;
   logic [TAG_W-1:0] io_req_tag;
   logic             io_fpu_en;
   logic [31:0]      io_fpu_a;
   logic [31:0]      io_fpu_b;
   logic [31:0]      io_fpu_s;
   logic             io_resp_valid;
   logic             io_resp_ready;
   logic [31:0]      io_resp_s;
   logic [TAG_W-1:0] io_resp_tag;
`ifdef FP_ADDSUB_STATUS_EN
   logic [2:0]       io_resp_flags;
`endif
   logic             io_busy;

   fp_addsub_issue #(.LATENCY(LAT), .FIFO_DEPTH(16), .TAG_W(TAG_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (io_req_valid),
      .io_req_ready  (io_req_ready),
      .io_req_op     (io_req_op),
      .io_req_a      (io_req_a),
      .io_req_b      (io_req_b),
      .io_req_tag    (io_req_tag),
      .io_fpu_en     (io_fpu_en),
      .io_fpu_a      (io_fpu_a),
      .io_fpu_b      (io_fpu_b),
      .io_fpu_s      (io_fpu_s),
      .io_resp_valid (io_resp_valid),
      .io_resp_ready (io_resp_ready),
      .io_resp_s     (io_resp_s),
      .io_resp_tag   (io_resp_tag),
`ifdef FP_ADDSUB_STATUS_EN
      .io_resp_flags (io_resp_flags),
`endif
      .io_busy       (io_busy)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- datapath stand-in ----------------
   // Known IEEE results for the named vectors; any other pair maps to an integer sum,
   // which is enough to expose operand or sign-routing errors.
   function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
      if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
      if (a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
      return a + b;
   endfunction

   logic [31:0] dp_pipe [LAT];
   always @(posedge clock) begin
      dp_pipe[0] <= dp_model(io_fpu_a, io_fpu_b);
      for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign io_fpu_s = dp_pipe[LAT-1];

   // ---------------- reference helpers ----------------
   function automatic logic [31:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eff_b;
      eff_b = (op == OP_SUB) ? (b ^ 32'h80000000) : b;
      return dp_model(a, eff_b);
   endfunction

   function automatic logic [2:0] ref_flags(input logic [31:0] s);
      int unsigned e, m;
      e = (s >> 23) & 32'hFF;
      m = s & 32'h7FFFFF;
      return {(e == 255 && m != 0), (e == 255 && m == 0), (e == 0 && m == 0)};
   endfunction

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [TAG_W+31:0] exp_q[$];
   int                acc_q[$];
   int                acc_cnt = 0;
   int                resp_cnt = 0;
   logic [31:0]       last_s;
   logic [TAG_W-1:0]  last_tag;
   int                last_lat;
   bit                track_gap = 0;
   bit                have_prev = 0;
   int                prev_cyc = 0;
   int                gap_err = 0;
   bit                prev_stall = 0;
   logic [TAG_W+31:0] held;

   always @(negedge clock) begin
      logic [TAG_W+31:0] e;
      int c;
      if (!reset) begin
         exp_q.delete();
         acc_q.delete();
         prev_stall = 0;
      end else begin
         if (io_req_valid && io_req_ready) begin
            exp_q.push_back({ref_result(io_req_op, io_req_a, io_req_b), io_req_tag});
            acc_q.push_back(cyc);
            acc_cnt++;
         end
         if (prev_stall && io_resp_valid)
            check("resp_stable", {io_resp_s, io_resp_tag}, held);
         prev_stall = io_resp_valid && !io_resp_ready;
         held = {io_resp_s, io_resp_tag};
         if (io_resp_valid && io_resp_ready) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               c = acc_q.pop_front();
               check("resp_s", io_resp_s, e[TAG_W+31:TAG_W]);
               check("resp_tag", io_resp_tag, e[TAG_W-1:0]);
`ifdef FP_ADDSUB_STATUS_EN
               check("resp_flags", io_resp_flags, ref_flags(e[TAG_W+31:TAG_W]));
`endif
               last_s   = io_resp_s;
               last_tag = io_resp_tag;
               last_lat = cyc - c;
               if (track_gap) begin
                  if (have_prev && cyc != prev_cyc + 1) gap_err++;
                  have_prev = 1;
                  prev_cyc  = cyc;
               end
               resp_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
      io_req_valid = 1'b1;
      io_req_op    = op;
      io_req_a     = a;
      io_req_b     = b;
      io_req_tag   = tag;
   endtask

   task automatic drive_rand(input logic [TAG_W-1:0] tag);
      drive_req(1'($urandom_range(0, 1)), $urandom, $urandom, tag);
   endtask

   task automatic wait_resp(input int target, input int budget);
      int k;
      k = 0;
      while (resp_cnt < target && k < budget) begin
         @(negedge clock);
         k++;
      end
      check("resp_wait_timeout", (resp_cnt >= target), 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              op;
      logic [31:0]       a;
      logic [31:0]       b;
      logic [TAG_W-1:0]  tag;
      logic [31:0]       exp_b;
      logic [31:0]       exp_s;
      logic [2:0]        exp_flags;
   } vec_t;

   localparam int NV = 6;
   vec_t vec [NV];

   initial begin
      int base;
      int drops;
      int vhigh;
      int k;

      vec[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'd3,  32'h40000000, 32'h40400000, 3'b000};
      vec[1] = '{OP_SUB, 32'h40400000, 32'h3F800000, 4'd5,  32'hBF800000, 32'h40000000, 3'b000};
      vec[2] = '{OP_SUB, 32'h3F800000, 32'h3F800000, 4'd9,  32'hBF800000, 32'h00000000, 3'b001};
      vec[3] = '{OP_ADD, 32'h7F800000, 32'h3F800000, 4'd12, 32'h3F800000, 32'h7F800000, 3'b010};
      vec[4] = '{OP_SUB, 32'h00000000, 32'h7FC00000, 4'd15, 32'hFFC00000, 32'hFFC00000, 3'b100};
      vec[5] = '{OP_SUB, 32'h00000000, 32'h80000000, 4'd0,  32'h00000000, 32'h00000000, 3'b001};

      reset         = 1'b0;
      io_req_valid  = 1'b0;
      io_req_op     = 1'b0;
      io_req_a      = '0;
      io_req_b      = '0;
      io_req_tag    = '0;
      io_resp_ready = 1'b1;

      // reset values
      repeat (3) @(negedge clock);
      check("rst_req_ready", io_req_ready, 1);
      check("rst_resp_valid", io_resp_valid, 0);
      check("rst_busy", io_busy, 0);
      check("rst_fpu_en", io_fpu_en, 0);
      check("rst_fpu_a", io_fpu_a, 0);
      check("rst_fpu_b", io_fpu_b, 0);
      check("rst_resp_s", io_resp_s, 0);
      check("rst_resp_tag", io_resp_tag, 0);
`ifdef FP_ADDSUB_STATUS_EN
      check("rst_flags", io_resp_flags, 0);
`endif
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("fpu_en_after_reset", io_fpu_en, 1);

      // table vectors, one at a time from an empty pipeline
      for (int i = 0; i < NV; i++) begin
         @(posedge clock); #1;
         drive_req(vec[i].op, vec[i].a, vec[i].b, vec[i].tag);
         base = resp_cnt;
         @(posedge clock); #1;
         io_req_valid = 1'b0;
         @(negedge clock);
         check("vec_fpu_a", io_fpu_a, vec[i].a);
         check("vec_fpu_b", io_fpu_b, vec[i].exp_b);
         check("vec_busy", io_busy, 1);
         wait_resp(base + 1, 40);
         check("vec_resp_s", last_s, vec[i].exp_s);
         check("vec_resp_tag", last_tag, vec[i].tag);
         check("vec_latency", last_lat, 15);
`ifdef FP_ADDSUB_STATUS_EN
         check("vec_flags", ref_flags(last_s), vec[i].exp_flags);
`endif
         repeat (2) @(posedge clock);
      end

      // back-to-back stream of 20
      io_resp_ready = 1'b1;
      base      = resp_cnt;
      drops     = 0;
      gap_err   = 0;
      have_prev = 0;
      track_gap = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         drive_rand(TAG_W'(i % 16));
         @(negedge clock);
         if (!io_req_ready) drops++;
      end
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      wait_resp(base + 20, 60);
      track_gap = 0;
      check("stream_ready_drops", drops, 0);
      check("stream_gaps", gap_err, 0);
      check("stream_count", resp_cnt - base, 20);

      // backpressure: fill all credits
      repeat (3) @(posedge clock);
      #1;
      io_resp_ready = 1'b0;
      base = acc_cnt;
      for (int i = 0; i < 24; i++) begin
         @(posedge clock); #1;
         drive_rand(TAG_W'(i));
      end
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      check("bp_accepts", acc_cnt - base, 16);
      repeat (20) @(negedge clock);
      check("bp_ready_full", io_req_ready, 0);
      check("bp_resp_valid", io_resp_valid, 1);
      check("bp_busy", io_busy, 1);
      @(posedge clock); #1;
      io_resp_ready = 1'b1;
      base = resp_cnt;
      @(negedge clock);
      check("bp_ready_before_pop", io_req_ready, 0);
      @(negedge clock);
      check("bp_ready_after_pop", io_req_ready, 1);
      wait_resp(base + 16, 40);
      check("bp_drained", exp_q.size(), 0);

      // reset with 3 results stored and 5 ops in flight
      @(posedge clock); #1;
      io_resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         drive_rand(TAG_W'(i));
      end
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      repeat (12) @(posedge clock);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         drive_rand(TAG_W'(i + 8));
      end
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      @(negedge clock);
      check("mid_resp_valid", io_resp_valid, 1);
      check("mid_in_flight", exp_q.size(), 8);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("mid_rst_busy", io_busy, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      io_resp_ready = 1'b1;
      vhigh = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (io_resp_valid) vhigh++;
      end
      check("post_rst_no_resp", vhigh, 0);
      check("post_rst_busy", io_busy, 0);
      check("post_rst_ready", io_req_ready, 1);

      // randomized traffic with random response backpressure
      for (int i = 0; i < 400; i++) begin
         @(posedge clock); #1;
         if ($urandom_range(0, 3) != 0) drive_rand(TAG_W'($urandom));
         else io_req_valid = 1'b0;
         io_resp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clock); #1;
      io_req_valid  = 1'b0;
      io_resp_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clock);
         k++;
      end
      repeat (2) @(negedge clock);
      check("rand_drained", exp_q.size(), 0);
      check("rand_idle_busy", io_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
